// File: rtl/tdm_demux4.sv
// Purpose : 4-slot TDM demultiplexer. Gathers a slot-ordered stream into four parallel lanes,
//           tracks frame alignment from a start-of-frame marker and flags framing violations.
// Latency : lanes and frame_valid update on the edge that accepts the slot-3 beat (visible next cycle).
// Backpr. : none; the block always accepts. din_valid low stalls slot tracking and holds all state.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   din[WIDTH]        slot data, sampled with sof only while din_valid is high
//   din_valid         beat qualifier
//   sof               start-of-frame; marks the beat that carries slot 0
//   out0..out3        registered lane outputs, updated together once per complete frame
//   sel[2]            slot index expected on the next valid beat
//   frame_valid       1-cycle pulse: out0..out3 were just updated
//   sync_err          1-cycle pulse: framing violation (missing or early sof)
//   locked            high while the aligner is in RUN
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [1:0]       sel,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked
);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] SLOT0 = 2'd0;
  localparam logic [1:0] SLOT1 = 2'd1;
  localparam logic [1:0] SLOT2 = 2'd2;
  localparam logic [1:0] SLOT3 = 2'd3;

  state_t           r_state;
  logic [1:0]       r_sel;
  logic [WIDTH-1:0] r_sh0;
  logic [WIDTH-1:0] r_sh1;
  logic [WIDTH-1:0] r_sh2;
  logic [WIDTH-1:0] r_out0;
  logic [WIDTH-1:0] r_out1;
  logic [WIDTH-1:0] r_out2;
  logic [WIDTH-1:0] r_out3;
  logic             r_frame_valid;
  logic             r_sync_err;
  logic             r_locked;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= HUNT;
      r_sel         <= SLOT0;
      r_sh0         <= '0;
      r_sh1         <= '0;
      r_sh2         <= '0;
      r_out0        <= '0;
      r_out1        <= '0;
      r_out2        <= '0;
      r_out3        <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      // Event flags are pulses: cleared every cycle unless re-raised below.
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;

      if (din_valid) begin
        case (r_state)
          HUNT: begin
            // Unmarked beats carry no alignment information and are dropped silently.
            if (sof) begin
              r_sh0    <= din;
              r_sel    <= SLOT1;
              r_state  <= RUN;
              r_locked <= 1'b1;
            end
          end

          RUN: begin
            if (sof) begin
              // A marker always restarts the frame at slot 0; if it arrived
              // mid-frame the partial frame is abandoned but lock is kept.
              if (r_sel != SLOT0) begin
                r_sync_err <= 1'b1;
              end
              r_sh0 <= din;
              r_sel <= SLOT1;
            end else begin
              case (r_sel)
                SLOT0: begin
                  // Slot 0 without its marker: alignment lost, beat discarded.
                  r_sync_err <= 1'b1;
                  r_state    <= HUNT;
                  r_locked   <= 1'b0;
                  r_sel      <= SLOT0;
                end
                SLOT1: begin
                  r_sh1 <= din;
                  r_sel <= SLOT2;
                end
                SLOT2: begin
                  r_sh2 <= din;
                  r_sel <= SLOT3;
                end
                default: begin
                  // Slot 3 completes the frame; all lanes commit on this edge
                  // so a consumer never sees a mix of two frames.
                  r_out0        <= r_sh0;
                  r_out1        <= r_sh1;
                  r_out2        <= r_sh2;
                  r_out3        <= din;
                  r_frame_valid <= 1'b1;
                  r_sel         <= SLOT0;
                end
              endcase
            end
          end

          default: begin
            r_state  <= HUNT;
            r_locked <= 1'b0;
            r_sel    <= SLOT0;
          end
        endcase
      end
    end
  end

  assign out0        = r_out0;
  assign out1        = r_out1;
  assign out2        = r_out2;
  assign out3        = r_out3;
  assign sel         = r_sel;
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;
  assign locked      = r_locked;

endmodule

// File: tb/tb_tdm_demux4.sv
// Purpose : directed self-checking bench for tdm_demux4 at WIDTH=2.
// Latency : each beat is driven on the falling edge and observed 1 time unit after the rising edge.
// Backpr. : none; din_valid gaps are driven explicitly by the scenarios.
module tb_tdm_demux4;

  logic       clk;
  logic       rst;
  logic [1:0] din;
  logic       din_valid;
  logic       sof;
  logic [1:0] out0, out1, out2, out3;
  logic [1:0] sel;
  logic       frame_valid, sync_err, locked;

  int n_checks;
  int n_fail;

  // Compact observation words: {locked, sel[1:0], frame_valid, sync_err} and the four lanes.
  logic [4:0] stat;
  logic [7:0] lanes;
  assign stat  = {locked, sel, frame_valid, sync_err};
  assign lanes = {out0, out1, out2, out3};

  tdm_demux4 #(.WIDTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .sof         (sof),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .sel         (sel),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [1:0] d, input logic s, input logic v);
    @(negedge clk);
    din       = d;
    sof       = s;
    din_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    din_valid = 1'b0;
    sof       = 1'b0;
    rst       = 1'b1;
    #2;
    rst       = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (stat !== 5'b0_00_0_0) begin
      n_fail++;
      $display("FAIL reset_stat got=%b exp=%b", stat, 5'b0_00_0_0);
    end
    n_checks++;
    if (lanes !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_lanes got=%b exp=%b", lanes, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lock_frame();
    logic [1:0] d [4];
    logic [4:0] e [4];
    d = '{2'b00, 2'b01, 2'b10, 2'b11};
    e = '{5'b1_01_0_0, 5'b1_10_0_0, 5'b1_11_0_0, 5'b1_00_1_0};
    for (int i = 0; i < 4; i++) begin
      step(d[i], (i == 0), 1'b1);
      n_checks++;
      if (stat !== e[i]) begin
        n_fail++;
        $display("FAIL lock_frame_beat%0d stat got=%b exp=%b", i, stat, e[i]);
      end
    end
    n_checks++;
    if (lanes !== 8'b00_01_10_11) begin
      n_fail++;
      $display("FAIL lock_frame_lanes got=%b exp=%b", lanes, 8'b00_01_10_11);
    end
    step(2'b00, 1'b0, 1'b0);
    n_checks++;
    if (stat !== 5'b1_00_0_0) begin
      n_fail++;
      $display("FAIL lock_frame_pulse_end stat got=%b exp=%b", stat, 5'b1_00_0_0);
    end
  endtask

  task automatic test_hunt_discard();
    logic [1:0] d [4];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(2'(i + 1), 1'b0, 1'b1);
      n_checks++;
      if (stat !== 5'b0_00_0_0 || lanes !== 8'h00) begin
        n_fail++;
        $display("FAIL hunt_discard_beat%0d stat=%b lanes=%b exp stat=%b lanes=%b",
                 i, stat, lanes, 5'b0_00_0_0, 8'h00);
      end
    end
    d = '{2'b11, 2'b10, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) begin
      step(d[i], (i == 0), 1'b1);
      if (i < 3) begin
        n_checks++;
        if (lanes !== 8'h00 || frame_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL hunt_partial_beat%0d lanes=%b fv=%b exp lanes=%b fv=0", i, lanes, frame_valid, 8'h00);
        end
      end
    end
    n_checks++;
    if (stat !== 5'b1_00_1_0 || lanes !== 8'b11_10_01_00) begin
      n_fail++;
      $display("FAIL hunt_frame stat=%b lanes=%b exp stat=%b lanes=%b",
               stat, lanes, 5'b1_00_1_0, 8'b11_10_01_00);
    end
  endtask

  task automatic test_gapped();
    logic [1:0] d [4];
    int fv_cnt;
    d = '{2'b00, 2'b01, 2'b10, 2'b11};
    fv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(d[i], (i == 0), 1'b1);
      if (frame_valid === 1'b1) fv_cnt++;
      if (i == 2) begin
        n_checks++;
        if (lanes !== 8'b11_10_01_00) begin
          n_fail++;
          $display("FAIL gapped_lanes_held got=%b exp=%b", lanes, 8'b11_10_01_00);
        end
      end
      if (i < 3) begin
        // Gap beats carry junk and sof=1 that must be ignored.
        for (int g = 0; g < 2; g++) begin
          step(2'b11, 1'b1, 1'b0);
          if (frame_valid === 1'b1) fv_cnt++;
          n_checks++;
          if (stat !== {1'b1, 2'(i + 1), 2'b00}) begin
            n_fail++;
            $display("FAIL gapped_gap%0d_%0d stat got=%b exp=%b", i, g, stat, {1'b1, 2'(i + 1), 2'b00});
          end
        end
      end
    end
    step(2'b00, 1'b0, 1'b0);
    if (frame_valid === 1'b1) fv_cnt++;
    n_checks++;
    if (lanes !== 8'b00_01_10_11) begin
      n_fail++;
      $display("FAIL gapped_lanes got=%b exp=%b", lanes, 8'b00_01_10_11);
    end
    n_checks++;
    if (fv_cnt !== 1) begin
      n_fail++;
      $display("FAIL gapped_fv_count got=%0d exp=1", fv_cnt);
    end
  endtask

  task automatic test_early_sof();
    logic [1:0] d [6];
    logic       s [6];
    logic [4:0] e [6];
    d = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    s = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    e = '{5'b1_01_0_0, 5'b1_10_0_0, 5'b1_01_0_1, 5'b1_10_0_0, 5'b1_11_0_0, 5'b1_00_1_0};
    for (int i = 0; i < 6; i++) begin
      step(d[i], s[i], 1'b1);
      n_checks++;
      if (stat !== e[i]) begin
        n_fail++;
        $display("FAIL early_sof_beat%0d stat got=%b exp=%b", i, stat, e[i]);
      end
      if (i == 2) begin
        n_checks++;
        if (lanes !== 8'b00_01_10_11) begin
          n_fail++;
          $display("FAIL early_sof_lanes_held got=%b exp=%b", lanes, 8'b00_01_10_11);
        end
      end
    end
    n_checks++;
    if (lanes !== 8'b10_11_00_01) begin
      n_fail++;
      $display("FAIL early_sof_lanes got=%b exp=%b", lanes, 8'b10_11_00_01);
    end
  endtask

  task automatic test_missing_sof();
    step(2'b11, 1'b1, 1'b1);
    step(2'b11, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b1);
    step(2'b10, 1'b0, 1'b1);
    n_checks++;
    if (stat !== 5'b1_00_1_0 || lanes !== 8'b11_11_00_10) begin
      n_fail++;
      $display("FAIL missing_sof_good_frame stat=%b lanes=%b exp stat=%b lanes=%b",
               stat, lanes, 5'b1_00_1_0, 8'b11_11_00_10);
    end
    step(2'b01, 1'b0, 1'b1);
    n_checks++;
    if (stat !== 5'b0_00_0_1) begin
      n_fail++;
      $display("FAIL missing_sof_err stat got=%b exp=%b", stat, 5'b0_00_0_1);
    end
    step(2'b01, 1'b0, 1'b0);
    n_checks++;
    if (stat !== 5'b0_00_0_0 || lanes !== 8'b11_11_00_10) begin
      n_fail++;
      $display("FAIL missing_sof_after stat=%b lanes=%b exp stat=%b lanes=%b",
               stat, lanes, 5'b0_00_0_0, 8'b11_11_00_10);
    end
  endtask

  task automatic test_reset_midframe();
    logic [1:0] d [4];
    step(2'b01, 1'b1, 1'b1);
    step(2'b10, 1'b0, 1'b1);
    n_checks++;
    if (stat !== 5'b1_10_0_0) begin
      n_fail++;
      $display("FAIL midreset_pre stat got=%b exp=%b", stat, 5'b1_10_0_0);
    end
    // Assert reset away from any clock edge and look before the next one.
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (stat !== 5'b0_00_0_0 || lanes !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_async stat=%b lanes=%b exp stat=%b lanes=%b", stat, lanes, 5'b0_00_0_0, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    step(2'b11, 1'b0, 1'b1);
    n_checks++;
    if (stat !== 5'b0_00_0_0) begin
      n_fail++;
      $display("FAIL midreset_needs_sof stat got=%b exp=%b", stat, 5'b0_00_0_0);
    end
    d = '{2'b00, 2'b11, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) step(d[i], (i == 0), 1'b1);
    n_checks++;
    if (stat !== 5'b1_00_1_0 || lanes !== 8'b00_11_01_10) begin
      n_fail++;
      $display("FAIL midreset_relock stat=%b lanes=%b exp stat=%b lanes=%b",
               stat, lanes, 5'b1_00_1_0, 8'b00_11_01_10);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] fv_seen;
    fv_seen = '0;
    for (int i = 0; i < 8; i++) begin
      step(2'(i), (i % 4 == 0), 1'b1);
      fv_seen[i] = frame_valid;
    end
    n_checks++;
    if (fv_seen !== 8'b1000_1000) begin
      n_fail++;
      $display("FAIL back_to_back_fv got=%b exp=%b", fv_seen, 8'b1000_1000);
    end
    n_checks++;
    if (lanes !== 8'b00_01_10_11) begin
      n_fail++;
      $display("FAIL back_to_back_lanes got=%b exp=%b", lanes, 8'b00_01_10_11);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    sof       = 1'b0;
    test_reset();
    test_lock_frame();
    test_hunt_discard();
    test_gapped();
    test_early_sof();
    test_missing_sof();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-slot time-division demultiplexer: the receiving end of a 4:1 mux whose select cycles 0,1,2,3. It takes a slot-ordered data stream with a start-of-frame marker, tracks the slot position, and presents all four slots in parallel on registered lane outputs once per complete frame. It sits downstream of `mux4_1`-style TDM sources and reports loss of frame alignment.

## Interface
- `WIDTH`, 1: bits per slot and per lane output.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-high.
- `din`  in  WIDTH  slot data for the current beat.
- `din_valid`  in  1  beat qualifier; `din`/`sof` are sampled only when high.
- `sof`  in  1  start of frame; marks the valid beat that carries slot 0.
- `out0`..`out3`  out  WIDTH each  lane outputs for slots 0..3, updated atomically per frame.
- `sel`  out  2  slot index expected on the next valid beat.
- `frame_valid`  out  1  one-cycle pulse: `out0..out3` were just updated.
- `sync_err`  out  1  one-cycle pulse: framing violation detected.
- `locked`  out  1  high while in RUN.

## Operation
- Internal state:
  - FSM {HUNT, RUN}.
  - 2-bit slot counter, driven directly on `sel`.
  - Shadow registers `sh0`..`sh2` of WIDTH bits each.
- Reset (async, immediate):
  - State HUNT.
  - `sel`=0, shadows=0, `out0..out3`=0.
  - `frame_valid`=0, `sync_err`=0, `locked`=0.
- HUNT:
  - Beats without `sof` are discarded; no error is flagged.
  - On a valid beat with `sof`=1: `sh0`<=`din`, `sel`<=1, go to RUN.
- RUN, on each valid beat:
  - `sel`=0, `sof`=1: `sh0`<=`din`, `sel`<=1.
  - `sel`=0, `sof`=0: missing marker. Pulse `sync_err`, go to HUNT, `sel`<=0, and discard the beat.
  - `sel`=1 or 2, `sof`=0: `sh[sel]`<=`din`, `sel`<=`sel`+1.
  - `sel`=3, `sof`=0: frame complete.
    - `out0`<=`sh0`, `out1`<=`sh1`, `out2`<=`sh2`, `out3`<=`din`, all on the same edge.
    - Pulse `frame_valid`.
    - `sel`<=0, which wraps around.
  - `sel`=1..3, `sof`=1: early marker. Pulse `sync_err` and discard the partial frame.
    - The beat is treated as a new slot 0: `sh0`<=`din`, `sel`<=1.
    - The FSM stays in RUN and outputs are unchanged.
- `din_valid`=0:
  - No state change; `sof` and `din` are ignored.
  - `frame_valid` and `sync_err` are 0.
- Lane outputs only change on a completed frame. A partial frame never reaches `out*`.
- `locked` = (state == RUN), registered with the state.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Latency: `out0..out3` and `frame_valid` change on the clock edge that accepts the slot-3 beat, and are visible in the following cycle.
- `frame_valid` and `sync_err` are high for exactly one cycle per event. They are mutually exclusive on a given edge.
- Back-to-back frames at full rate give a `frame_valid` pulse every 4 cycles.
- Gaps in `din_valid` stretch a frame arbitrarily. Slot position is kept across gaps.
- Reset asserted mid-frame clears outputs and shadows immediately. After release, the block requires `sof` to relock.
- `sel` after a valid beat reflects the next expected slot in the following cycle.

## Test plan
- **Lock and single frame.** WIDTH=2, reset, then 4 consecutive valid beats: `din`=00,01,10,11 with `sof` on the first.
  - Required: `locked`=1 after beat 1, `sel` goes 1,2,3,0.
  - After beat 4: `out0..3`=00,01,10,11 with `frame_valid`=1 for one cycle, `sync_err` never set.
- **Hunt discard.** 3 valid beats without `sof`, then a full frame 11,10,01,00.
  - Required: no `frame_valid` and no `sync_err` during the hunt.
  - Outputs stay 0 until the frame completes, then read 11,10,01,00.
- **Gapped frame.** The frame from scenario 1 with `din_valid` low for 2 cycles between each beat.
  - Required: identical outputs, a single `frame_valid` pulse, and `sel` holding its value through the gaps.
- **Early sof.** Beats 00(`sof`),01, then 10 with `sof`=1, then 11,00,01.
  - Required: `sync_err` pulse on the 3rd beat and `locked` stays 1.
  - On the last beat: `frame_valid` with outputs 10,11,00,01.
- **Missing sof.** After one good frame, the next beat arrives with `sof`=0.
  - Required: `sync_err` pulse, `locked`=0, `sel`=0.
  - Previous outputs are retained until the next complete frame.
- **Reset mid-frame.** Assert `rst` asynchronously after 2 beats.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - The next frame requires `sof` and produces correct lanes.
